ghost_motion_ctrl: RTL and testbench

//  Parametrised ghost movement controller: next generation of the per-ghost movers.

---
 rtl/ghost_pkg.sv | 37 +++
 rtl/ghost_lfsr.sv | 24 ++
 rtl/ghost_motion_ctrl.sv | 159 +++++++++++++++
 tb/tb_ghost_motion_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// ghost_pkg: shared constants and types for the ghost movement controller.
//   DIR_*   heading encodings (UP/DOWN on y, LEFT/RIGHT on x)
//   MODE_*  behaviour modes driven by the game controller
//   ghost_state_e  FSM state encoding
//   ghost_dbg_t    debug view of FSM state, retry count and LFSR
//   reverse()      opposite heading; UP<->DOWN and LEFT<->RIGHT differ only in bit 0
package ghost_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [1:0] MODE_RANDOM = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_FRIGHT = 2'd2;
  localparam logic [1:0] MODE_FREEZE = 2'd3;

  localparam int TRIES_W = 8;

  typedef enum logic [1:0] {
    ST_MOVE   = 2'd0,
    ST_TURN   = 2'd1,
    ST_SETTLE = 2'd2
  } ghost_state_e;

  typedef struct packed {
    ghost_state_e        state;
    logic [TRIES_W-1:0]  tries;
    logic [15:0]         lfsr;
  } ghost_dbg_t;

  function automatic logic [1:0] reverse(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/ghost_lfsr.sv
// ghost_lfsr: 16-bit Galois LFSR (right-shifting) with enable.
//   clk, rst  system clock, synchronous active-high reset (loads SEED)
//   en        advance one step this cycle
//   value     current LFSR contents
module ghost_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else if (en) begin
      // Bit shifted out feeds back into the tap positions.
      value <= {1'b0, value[15:1]} ^ (value[0] ? TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/ghost_motion_ctrl.sv
// ghost_motion_ctrl: one ghost's position/heading controller.
//   clk, rst    system clock, synchronous active-high reset
//   move_tick   one-cycle step enable (no handshake; a tick is consumed or dropped in its cycle)
//   wall_ahead  next step along the current heading is blocked
//   mode        RANDOM / CHASE / FRIGHT / FREEZE
//   tgt_x/y     chase target
//   x, y        ghost pixel position (wraps modulo 2^X_W / 2^Y_W)
//   direction   current heading
//   next_dir    candidate heading the next TURN would take (combinational)
//   turning     high while in TURN or SETTLE
//   dbg         FSM state, retry count and LFSR contents
module ghost_motion_ctrl
  import ghost_pkg::*;
#(
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter int          START_X   = 595,
  parameter int          START_Y   = 435,
  parameter logic [1:0]  START_DIR = 2'b10,
  parameter int          STEP      = 1,
  parameter int          CHK_LAT   = 2,
  parameter int          MAX_TRIES = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           move_tick,
  input  logic           wall_ahead,
  input  logic [1:0]     mode,
  input  logic [X_W-1:0] tgt_x,
  input  logic [Y_W-1:0] tgt_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     direction,
  output logic [1:0]     next_dir,
  output logic           turning,
  output ghost_dbg_t     dbg
);

  localparam int CNT_W = (CHK_LAT < 1) ? 1 : $clog2(CHK_LAT + 1);
  localparam int D_W   = (X_W > Y_W) ? X_W : Y_W;

  localparam logic [X_W-1:0]     X0       = X_W'(START_X);
  localparam logic [Y_W-1:0]     Y0       = Y_W'(START_Y);
  localparam logic [X_W-1:0]     X_STEP   = X_W'(STEP);
  localparam logic [Y_W-1:0]     Y_STEP   = Y_W'(STEP);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(CHK_LAT);
  localparam logic [TRIES_W-1:0] MAX_T    = TRIES_W'(MAX_TRIES);

  ghost_state_e       state;
  logic [CNT_W-1:0]   cnt;
  logic [TRIES_W-1:0] tries;
  logic [1:0]         prev_mode;
  logic [1:0]         pre_dir;    // heading when the current wall episode began
  logic [15:0]        lfsr_q;
  logic               frozen;
  logic               fright_entry;

  assign frozen       = (mode == MODE_FREEZE);
  assign fright_entry = (mode == MODE_FRIGHT) && (prev_mode != MODE_FRIGHT);

  ghost_lfsr #(.SEED(LFSR_SEED), .TAPS(16'hB400)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (!frozen),
    .value (lfsr_q)
  );

  // Chase target selection: larger |delta| axis wins, ties to x. Odd retry
  // counts flip the axis so successive retries alternate between axes.
  logic [D_W-1:0] adx, ady;
  logic           use_x;
  logic [1:0]     cand;

  always_comb begin
    adx   = D_W'((tgt_x >= x) ? (tgt_x - x) : (x - tgt_x));
    ady   = D_W'((tgt_y >= y) ? (tgt_y - y) : (y - tgt_y));
    use_x = (adx >= ady) ^ tries[0];
    cand  = lfsr_q[1:0];
    if (mode == MODE_CHASE) begin
      if (use_x) cand = (tgt_x > x) ? DIR_RIGHT : DIR_LEFT;
      else       cand = (tgt_y > y) ? DIR_DOWN  : DIR_UP;
    end
    next_dir = cand;
    // Avoid doubling back unless the forced-reverse fallback is due.
    if ((cand == reverse(direction)) && (tries != MAX_T)) begin
      next_dir = lfsr_q[1:0] ^ 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= X0;
      y         <= Y0;
      direction <= START_DIR;
      pre_dir   <= START_DIR;
      state     <= ST_MOVE;
      cnt       <= '0;
      tries     <= '0;
      prev_mode <= mode;
    end else begin
      prev_mode <= mode;
      if (!frozen) begin
        if (fright_entry) begin
          // Fright reverses at once and lets the checker re-validate via SETTLE.
          direction <= reverse(direction);
          pre_dir   <= reverse(direction);
          state     <= ST_SETTLE;
          cnt       <= CNT_LOAD;
          tries     <= '0;
        end else begin
          case (state)
            ST_MOVE: begin
              if (wall_ahead) begin
                pre_dir <= direction;
                state   <= ST_TURN;
              end else if (move_tick) begin
                case (direction)
                  DIR_UP:    y <= y - Y_STEP;
                  DIR_DOWN:  y <= y + Y_STEP;
                  DIR_LEFT:  x <= x - X_STEP;
                  default:   x <= x + X_STEP;
                endcase
              end
            end
            ST_TURN: begin
              if (tries == MAX_T) begin
                direction <= reverse(pre_dir);
                tries     <= '0;
              end else begin
                direction <= next_dir;
              end
              cnt   <= CNT_LOAD;
              state <= ST_SETTLE;
            end
            ST_SETTLE: begin
              if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
              end else if (wall_ahead) begin
                tries <= tries + TRIES_W'(1);
                state <= ST_TURN;
              end else begin
                tries <= '0;
                state <= ST_MOVE;
              end
            end
            default: state <= ST_MOVE;
          endcase
        end
      end
    end
  end

  assign turning   = (state == ST_TURN) || (state == ST_SETTLE);
  assign dbg.state = state;
  assign dbg.tries = tries;
  assign dbg.lfsr  = lfsr_q;

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
module tb_ghost_motion_ctrl;
  import ghost_pkg::*;

  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int START_X   = 595;
  localparam int START_Y   = 435;
  localparam int STEP      = 1;
  localparam int CHK_LAT   = 2;
  localparam int MAX_TRIES = 4;
  localparam int EXP_W     = X_W + Y_W + 2 + 1 + 8 + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, move_tick, wall_ahead, turning;
  logic [1:0]     mode, direction, next_dir;
  logic [X_W-1:0] tgt_x, x;
  logic [Y_W-1:0] tgt_y, y;
  ghost_dbg_t     dbg;

  ghost_motion_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .START_X(START_X), .START_Y(START_Y), .START_DIR(2'b10),
    .STEP(STEP), .CHK_LAT(CHK_LAT), .MAX_TRIES(MAX_TRIES), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .wall_ahead(wall_ahead), .mode(mode),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .x(x), .y(y), .direction(direction),
    .next_dir(next_dir), .turning(turning), .dbg(dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Ghost described as position + heading + "what it is doing":
  // cruising, about to pick a heading, or waiting out the checker latency.
  int         mx, my, mtries, mwait;
  logic [1:0] mdir, mprev, mpre;
  logic [15:0] mlfsr;
  bit         m_pick_pending, m_waiting;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [1:0] model_next_dir();
    int dx, dy, adx, ady;
    bit prefer_x;
    logic [1:0] c, r;
    r = mlfsr[1:0];
    c = r;
    if (mode == MODE_CHASE) begin
      dx = int'(tgt_x) - mx;
      dy = int'(tgt_y) - my;
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      prefer_x = (adx >= ady);
      if (mtries % 2 == 1) prefer_x = !prefer_x;
      if (prefer_x) c = (dx > 0) ? DIR_RIGHT : DIR_LEFT;
      else          c = (dy > 0) ? DIR_DOWN : DIR_UP;
    end
    if (c == (mdir ^ 2'b01) && mtries != MAX_TRIES) c = r ^ 2'b01;
    return c;
  endfunction

  task automatic model_update();
    logic [1:0] nd;
    bit entering;
    if (rst) begin
      mx = START_X; my = START_Y; mdir = DIR_LEFT; mpre = DIR_LEFT;
      mlfsr = 16'hACE1; mtries = 0; mwait = 0;
      m_pick_pending = 0; m_waiting = 0; mprev = mode;
    end else begin
      entering = (mode == MODE_FRIGHT) && (mprev != MODE_FRIGHT);
      mprev = mode;
      if (mode != MODE_FREEZE) begin
        nd = model_next_dir();
        mlfsr = galois(mlfsr);
        if (entering) begin
          mdir = mdir ^ 2'b01; mpre = mdir;
          m_pick_pending = 0; m_waiting = 1; mwait = CHK_LAT; mtries = 0;
        end else if (m_pick_pending) begin
          if (mtries == MAX_TRIES) begin mdir = mpre ^ 2'b01; mtries = 0; end
          else mdir = nd;
          m_pick_pending = 0; m_waiting = 1; mwait = CHK_LAT;
        end else if (m_waiting) begin
          if (mwait > 0) mwait--;
          else if (wall_ahead) begin mtries++; m_waiting = 0; m_pick_pending = 1; end
          else begin mtries = 0; m_waiting = 0; end
        end else if (wall_ahead) begin
          mpre = mdir; m_pick_pending = 1;
        end else if (move_tick) begin
          case (mdir)
            DIR_UP:   my = (my + (1 << Y_W) - STEP) % (1 << Y_W);
            DIR_DOWN: my = (my + STEP) % (1 << Y_W);
            DIR_LEFT: mx = (mx + (1 << X_W) - STEP) % (1 << X_W);
            default:  mx = (mx + STEP) % (1 << X_W);
          endcase
        end
      end
    end
    exp_q.push_back({X_W'(mx), Y_W'(my), mdir, (m_pick_pending | m_waiting), 8'(mtries), mlfsr});
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("x",         x,           e[45:36]);
      chk("y",         y,           e[35:27]);
      chk("direction", direction,   e[26:25]);
      chk("turning",   turning,     e[24]);
      chk("tries",     dbg.tries,   e[23:16]);
      chk("lfsr",      dbg.lfsr,    e[15:0]);
      chk("next_dir",  next_dir,    model_next_dir());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_wall();
    wall_ahead = 1'b1;
    step();
    wall_ahead = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  h, cur_mode;
    logic [15:0] saved_lfsr;
    int          r;

    rst = 1'b1; move_tick = 1'b0; wall_ahead = 1'b0; mode = MODE_RANDOM;
    tgt_x = '0; tgt_y = '0;
    step();
    rst = 1'b0;
    chk("reset_x", x, 595);
    chk("reset_y", y, 435);
    chk("reset_dir", direction, 2'b10);
    chk("reset_turning", turning, 0);
    chk("reset_lfsr", dbg.lfsr, 16'hACE1);
    chk("reset_tries", dbg.tries, 0);

    // 10 free steps left
    move_tick = 1'b1;
    run(10);
    move_tick = 1'b0;
    chk("t1_x", x, 585);
    chk("t1_y", y, 435);
    chk("t1_dir", direction, 2'b10);

    // wall with simultaneous tick: no step, turn begins
    wall_ahead = 1'b1; move_tick = 1'b1;
    step();
    wall_ahead = 1'b0; move_tick = 1'b0;
    chk("t2_no_step", x, 585);
    chk("t2_turning", turning, 1);
    chk("t2_dir_held", direction, 2'b10);
    step();
    chk("t2_turning_turn", turning, 1);
    run(CHK_LAT);
    chk("t2_still_settling", turning, 1);
    step();
    chk("t2_back_to_move", turning, 0);
    chk("t2_tries", dbg.tries, 0);

    // persistent wall: MAX_TRIES failed headings, then forced reverse
    h = mdir;
    wall_ahead = 1'b1;
    run(17);
    chk("t3_tries_max", dbg.tries, MAX_TRIES);
    step();
    chk("t3_forced_reverse", direction, h ^ 2'b01);
    chk("t3_tries_cleared", dbg.tries, 0);
    wall_ahead = 1'b0;
    run(CHK_LAT + 1);
    chk("t3_move", turning, 0);

    // chase: navigate to (100,100) heading right
    rst = 1'b1; step(); rst = 1'b0;
    move_tick = 1'b1; run(495); move_tick = 1'b0;
    chk("t4_x100", x, 100);
    mode = MODE_CHASE; tgt_x = 10'd100; tgt_y = 9'd0;
    pulse_wall(); step();
    chk("t4_turn_up", direction, DIR_UP);
    run(CHK_LAT + 1);
    move_tick = 1'b1; run(335); move_tick = 1'b0;
    chk("t4_pos_x", x, 100);
    chk("t4_pos_y", y, 100);
    tgt_x = 10'd300; tgt_y = 9'd100;
    pulse_wall(); step();
    chk("t4_face_right", direction, DIR_RIGHT);
    run(CHK_LAT + 1);
    tgt_y = 9'd120;
    wall_ahead = 1'b1;
    step(); step();
    chk("t4_first_try_x", direction, 2'b11);
    run(CHK_LAT + 1); step();
    chk("t4_second_try_y", direction, 2'b01);
    wall_ahead = 1'b0;
    run(CHK_LAT + 1);
    chk("t4_move", turning, 0);
    mode = MODE_RANDOM;

    // tunnel wrap and fright reversal
    rst = 1'b1; step(); rst = 1'b0;
    move_tick = 1'b1; run(595);
    chk("t5_x0", x, 0);
    step();
    chk("t5_wrap", x, 1023);
    move_tick = 1'b0;
    mode = MODE_FRIGHT;
    step();
    chk("t5_fright_rev", direction, DIR_RIGHT);
    chk("t5_fright_settle", turning, 1);
    mode = MODE_RANDOM;
    run(CHK_LAT + 1);
    chk("t5_move", turning, 0);

    // freeze holds everything; reset mid-settle
    saved_lfsr = mlfsr;
    mode = MODE_FREEZE; move_tick = 1'b1; wall_ahead = 1'b1;
    run(50);
    chk("t6_x_frozen", x, 1023);
    chk("t6_y_frozen", y, 435);
    chk("t6_dir_frozen", direction, DIR_RIGHT);
    chk("t6_lfsr_frozen", dbg.lfsr, saved_lfsr);
    chk("t6_state_frozen", turning, 0);
    mode = MODE_RANDOM; move_tick = 1'b0; wall_ahead = 1'b0;
    pulse_wall(); step(); step();
    chk("t6_in_settle", turning, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst_x", x, 595);
    chk("t6_rst_y", y, 435);
    chk("t6_rst_dir", direction, 2'b10);
    chk("t6_rst_turning", turning, 0);
    chk("t6_rst_lfsr", dbg.lfsr, 16'hACE1);

    // randomized traffic against the model
    cur_mode = MODE_RANDOM;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 40)      cur_mode = MODE_RANDOM;
        else if (r < 75) cur_mode = MODE_CHASE;
        else if (r < 88) cur_mode = MODE_FRIGHT;
        else             cur_mode = MODE_FREEZE;
      end
      if ($urandom_range(0, 49) == 0) begin
        tgt_x = X_W'($urandom_range(0, 1023));
        tgt_y = Y_W'($urandom_range(0, 511));
      end
      mode       = cur_mode;
      move_tick  = ($urandom_range(0, 1) == 1);
      wall_ahead = ($urandom_range(0, 4) == 0);
      rst        = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
